cardinal_nic_ctrl: RTL

- Autonomous driver for the cardinal NIC processor-side port: addr, d_in, nicEn, nicWrEn, d_out.
- A requester pushes 64-bit packets into a TX FIFO. The block polls the NIC output status register and writes a packet into the output buffer only when the NIC channel is free.
- It also polls the NIC input status register and drains received packets into an RX FIFO.
- Sits between a core (or DMA engine) and one cardinal NIC, and replaces software polling loops.

---
 rtl/cardinal_nic_ctrl_if.sv | 24 ++
 rtl/cardinal_nic_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic_ctrl_if.sv
// rtl/cardinal_nic_ctrl_if.sv - TX/RX packet streams and NIC processor-port bundle
interface cardinal_nic_ctrl_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] rx_data;
  logic [1:0]  nic_addr;
  logic        nic_en;
  logic        nic_wr_en;
  logic [63:0] nic_d_in;
  logic [63:0] nic_d_out;

  modport master (
    input  tx_valid, tx_data, rx_ready, nic_d_out,
    output tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_wr_en, nic_d_in
  );

  modport slave (
    output tx_valid, tx_data, rx_ready, nic_d_out,
    input  tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_wr_en, nic_d_in
  );
endinterface

// File: rtl/cardinal_nic_ctrl.sv
// rtl/cardinal_nic_ctrl.sv - autonomous cardinal NIC poller with TX and RX packet FIFOs
module cardinal_nic_ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count only, so a pop never frees a slot for a same-cycle push
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module cardinal_nic_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  cardinal_nic_ctrl_if.master         bus,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [15:0]                 sent_cnt,
  output logic [15:0]                 recv_cnt
);
  localparam logic [1:0] ADDR_IBUF = 2'b00;
  localparam logic [1:0] ADDR_ISTAT = 2'b01;
  localparam logic [1:0] ADDR_OBUF = 2'b10;
  localparam logic [1:0] ADDR_OSTAT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_OSTAT,
    CHK_OSTAT,
    WR_OBUF,
    RD_ISTAT,
    CHK_ISTAT,
    RD_IBUF,
    CAP_IBUF
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        turn_rx;
  logic        turn_rx_nxt;
  logic        tx_pop;
  logic        rx_push;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic [63:0] tx_head;

  cardinal_nic_ctrl_fifo #(.DEPTH(TX_DEPTH), .WIDTH(64)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.tx_valid),
    .pop   (tx_pop),
    .wdata (bus.tx_data),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  cardinal_nic_ctrl_fifo #(.DEPTH(RX_DEPTH), .WIDTH(64)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (bus.rx_ready),
    .wdata (bus.nic_d_out),
    .rdata (bus.rx_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign bus.tx_ready = !tx_full;
  assign bus.rx_valid = !rx_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      turn_rx  <= 1'b0;
      sent_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      state   <= state_nxt;
      turn_rx <= turn_rx_nxt;
      if (tx_pop)  sent_cnt <= sent_cnt + 16'd1;
      if (rx_push) recv_cnt <= recv_cnt + 16'd1;
    end
  end

  // NIC port is a pure decode of state; the CHK states sample the read issued one cycle earlier
  always_comb begin
    state_nxt     = state;
    turn_rx_nxt   = turn_rx;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    bus.nic_en    = 1'b0;
    bus.nic_wr_en = 1'b0;
    bus.nic_addr  = ADDR_IBUF;
    bus.nic_d_in  = '0;
    case (state)
      IDLE: begin
        if (!enable)                    state_nxt = IDLE;
        else if (!turn_rx && !tx_empty) state_nxt = RD_OSTAT;
        else if (!rx_full)              state_nxt = RD_ISTAT;
        else if (!tx_empty)             state_nxt = RD_OSTAT;
        else                            state_nxt = IDLE;
      end
      RD_OSTAT: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = ADDR_OSTAT;
        state_nxt    = CHK_OSTAT;
      end
      CHK_OSTAT: begin
        if (bus.nic_d_out[63]) begin
          turn_rx_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          state_nxt   = WR_OBUF;
        end
      end
      WR_OBUF: begin
        bus.nic_en    = 1'b1;
        bus.nic_wr_en = 1'b1;
        bus.nic_addr  = ADDR_OBUF;
        bus.nic_d_in  = tx_head;
        tx_pop        = 1'b1;
        turn_rx_nxt   = 1'b1;
        state_nxt     = IDLE;
      end
      RD_ISTAT: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = ADDR_ISTAT;
        state_nxt    = CHK_ISTAT;
      end
      CHK_ISTAT: begin
        if (bus.nic_d_out[63]) begin
          state_nxt   = RD_IBUF;
        end else begin
          turn_rx_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      RD_IBUF: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = ADDR_IBUF;
        state_nxt    = CAP_IBUF;
      end
      CAP_IBUF: begin
        // the slot was reserved at the RD_ISTAT decision; only this FSM pushes RX
        rx_push     = 1'b1;
        turn_rx_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
